// File: rtl/tictactoe_top.sv
// Two-player tic-tac-toe controller: holds the 3x3 board, alternates turns,
// rejects illegal moves and reports win/draw from registered state.
module tictactoe_top (
   input  logic        ph1,
   input  logic        ph2,
   input  logic        reset,
   input  logic        isPlayer1Start,
   input  logic        playerWrite,
   input  logic [3:0]  playerInput,
   output logic [17:0] gBoard,
   output logic [2:0]  outputState,
   output logic        gameIsDone,
   output logic [1:0]  winner
);

   typedef enum logic [2:0] {
      P1_TURN = 3'd1,
      P2_TURN = 3'd2,
      P1_WIN  = 3'd3,
      P2_WIN  = 3'd4,
      DRAW    = 3'd5
   } state_t;

   state_t state;

   // ph2 is an interface leftover; nothing depends on it.
   logic unusedPh2;
   assign unusedPh2 = ph2;

   logic        isTurn;
   logic [1:0]  mover;
   logic        targetEmpty;
   logic        legal;
   logic [17:0] nextBoard;
   logic        moverWins;
   logic        boardFull;

   function automatic logic lineOwned(input logic [17:0] b, input int a, input int m,
                                      input int c, input logic [1:0] code);
      return (b[2*a +: 2] == code) && (b[2*m +: 2] == code) && (b[2*c +: 2] == code);
   endfunction

   always_comb begin
      isTurn      = (state == P1_TURN) || (state == P2_TURN);
      mover       = (state == P2_TURN) ? 2'b10 : 2'b01;
      targetEmpty = 1'b0;
      for (int i = 0; i < 9; i++)
         if (playerInput == 4'(i)) targetEmpty = (gBoard[2*i +: 2] == 2'b00);
      // Indices 9..15 never match a cell, so targetEmpty stays low for them.
      legal     = isTurn && playerWrite && targetEmpty;
      nextBoard = gBoard;
      for (int i = 0; i < 9; i++)
         if (legal && playerInput == 4'(i)) nextBoard[2*i +: 2] = mover;
      moverWins = lineOwned(nextBoard, 0, 1, 2, mover) || lineOwned(nextBoard, 3, 4, 5, mover) ||
                  lineOwned(nextBoard, 6, 7, 8, mover) || lineOwned(nextBoard, 0, 3, 6, mover) ||
                  lineOwned(nextBoard, 1, 4, 7, mover) || lineOwned(nextBoard, 2, 5, 8, mover) ||
                  lineOwned(nextBoard, 0, 4, 8, mover) || lineOwned(nextBoard, 2, 4, 6, mover);
      boardFull = 1'b1;
      for (int i = 0; i < 9; i++)
         if (nextBoard[2*i +: 2] == 2'b00) boardFull = 1'b0;
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         gBoard     <= '0;
         winner     <= 2'b00;
         gameIsDone <= 1'b0;
         state      <= isPlayer1Start ? P1_TURN : P2_TURN;
      end else begin
         case (state)
            P1_TURN, P2_TURN: begin
               if (legal) begin
                  gBoard <= nextBoard;
                  if (moverWins) begin
                     state      <= (state == P1_TURN) ? P1_WIN : P2_WIN;
                     winner     <= mover;
                     gameIsDone <= 1'b1;
                  end else if (boardFull) begin
                     state      <= DRAW;
                     winner     <= 2'b11;
                     gameIsDone <= 1'b1;
                  end else begin
                     state <= (state == P1_TURN) ? P2_TURN : P1_TURN;
                  end
               end
            end
            P1_WIN, P2_WIN, DRAW: ;
            default: begin
               state      <= P1_TURN;
               winner     <= 2'b00;
               gameIsDone <= 1'b0;
            end
         endcase
      end
   end

   assign outputState = state;

endmodule

// File: tb/tb_tictactoe_top.sv
// Directed bench for tictactoe_top: hand-computed boards and states after
// each move, with immediate assertions at every check point.
module tb_tictactoe_top;

   logic        ph1 = 1'b0;
   logic        ph2 = 1'b1;
   logic        reset = 1'b0;
   logic        isPlayer1Start = 1'b0;
   logic        playerWrite = 1'b0;
   logic [3:0]  playerInput = 4'd0;
   logic [17:0] gBoard;
   logic [2:0]  outputState;
   logic        gameIsDone;
   logic [1:0]  winner;

   int nTests = 0;
   int nFail  = 0;

   always #5 ph1 = ~ph1;
   always #5 ph2 = ~ph2;

   tictactoe_top dut (
      .ph1(ph1), .ph2(ph2), .reset(reset), .isPlayer1Start(isPlayer1Start),
      .playerWrite(playerWrite), .playerInput(playerInput), .gBoard(gBoard),
      .outputState(outputState), .gameIsDone(gameIsDone), .winner(winner)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic doReset(input logic p1First);
      @(negedge ph1);
      reset = 1'b1; isPlayer1Start = p1First; playerWrite = 1'b0;
      @(posedge ph1); #1;
      reset = 1'b0;
   endtask

   task automatic move(input logic [3:0] idx);
      @(negedge ph1);
      playerWrite = 1'b1; playerInput = idx;
      @(posedge ph1); #1;
      playerWrite = 1'b0;
   endtask

   task automatic chkAll(input string tag, input logic [17:0] b, input logic [2:0] s,
                         input logic d, input logic [1:0] w);
      chk({tag, ".board"}, 32'(gBoard), 32'(b));
      chk({tag, ".state"}, 32'(outputState), 32'(s));
      chk({tag, ".done"}, 32'(gameIsDone), 32'(d));
      chk({tag, ".winner"}, 32'(winner), 32'(w));
   endtask

   initial begin
      // 1: reset, player 2 first
      doReset(1'b0);
      chkAll("rst_p2", 18'h00000, 3'd2, 1'b0, 2'b00);
      // 2: legal move, occupied cell, out-of-range index
      move(4'd4);
      chkAll("p2_c4", 18'h00200, 3'd1, 1'b0, 2'b00);
      move(4'd4);
      chkAll("occupied", 18'h00200, 3'd1, 1'b0, 2'b00);
      move(4'd12);
      chkAll("badidx", 18'h00200, 3'd1, 1'b0, 2'b00);
      @(negedge ph1); playerInput = 4'd0;
      @(posedge ph1); #1;
      chkAll("nowrite", 18'h00200, 3'd1, 1'b0, 2'b00);

      // 3: player 2 wins top row
      doReset(1'b0);
      move(4'd0); move(4'd3); move(4'd1); move(4'd4);
      chkAll("s3_mid", 18'h0014A, 3'd2, 1'b0, 2'b00);
      move(4'd2);
      chkAll("p2win", 18'h0016A, 3'd4, 1'b1, 2'b10);
      move(4'd8);
      chkAll("p2win_hold", 18'h0016A, 3'd4, 1'b1, 2'b10);

      // 4: draw on full board
      doReset(1'b1);
      move(4'd0); move(4'd4); move(4'd1); move(4'd2); move(4'd6);
      move(4'd3); move(4'd5); move(4'd7);
      chkAll("s4_pre", 18'h096A5, 3'd1, 1'b0, 2'b00);
      move(4'd8);
      chkAll("draw", 18'h196A5, 3'd5, 1'b1, 2'b11);

      // 5: player 1 wins anti-diagonal
      doReset(1'b1);
      move(4'd2); move(4'd0); move(4'd4); move(4'd1); move(4'd6);
      chkAll("p1win", 18'h0111A, 3'd3, 1'b1, 2'b01);

      // 6: reset mid-game, then reset colliding with a write
      doReset(1'b0);
      move(4'd0); move(4'd3); move(4'd1);
      chkAll("s6_mid", 18'h0004A, 3'd1, 1'b0, 2'b00);
      doReset(1'b1);
      chkAll("rst_mid", 18'h00000, 3'd1, 1'b0, 2'b00);
      @(negedge ph1);
      reset = 1'b1; isPlayer1Start = 1'b0; playerWrite = 1'b1; playerInput = 4'd5;
      @(posedge ph1); #1;
      reset = 1'b0; playerWrite = 1'b0;
      chkAll("rst_vs_wr", 18'h00000, 3'd2, 1'b0, 2'b00);

      // Write held high across two edges: each edge is a move by the player on turn
      doReset(1'b1);
      @(negedge ph1); playerWrite = 1'b1; playerInput = 4'd0;
      @(negedge ph1); playerInput = 4'd1;
      @(posedge ph1); #1; playerWrite = 1'b0;
      chkAll("held_wr", 18'h00009, 3'd1, 1'b0, 2'b00);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/tictactoe_top.md
Name: tictactoe_top

Overview:
- Two-player tic-tac-toe game controller. It holds the 3x3 board, alternates turns and rejects illegal moves.
- It detects a win or a draw and reports the game state.
- It is the top of the game datapath. Players drive a cell index plus a write strobe; the board vector feeds display and host logic.

Parameters:
- None. The board size is fixed at 3x3 (9 cells, 2 bits per cell, 18-bit board).

Ports:
- ph1  input  1  system clock; all state updates on the rising edge of ph1.
- ph2  input  1  second clock phase, kept for interface compatibility; unused internally, no logic depends on it.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of ph1.
- isPlayer1Start  input  1  1 = player 1 moves first, 0 = player 2 moves first; sampled while reset is high.
- playerWrite  input  1  move strobe; a move is attempted on every rising ph1 edge where it is 1.
- playerInput  input  4  target cell index 0..8; values 9..15 are invalid.
- gBoard  output  18  board; cell i occupies gBoard[2i+1:2i]. Encoding: 00 empty, 01 player 1, 10 player 2; 11 never produced.
- outputState  output  3  FSM state code (see Behaviour).
- gameIsDone  output  1  high in any terminal state.
- winner  output  2  00 none/in progress, 01 player 1, 10 player 2, 11 draw.

Behaviour:
- One clock: ph1 with synchronous active-high reset. Every output is a registered value or decoded from registers; there are no combinational paths from inputs to outputs.

Reset (on a ph1 edge with reset=1):
- gBoard = 0, winner = 00, gameIsDone = 0.
- state = P1_TURN if isPlayer1Start=1, else P2_TURN.

FSM state codes (outputState):
- 3'd1 P1_TURN, 3'd2 P2_TURN, 3'd3 P1_WIN, 3'd4 P2_WIN, 3'd5 DRAW.
- Codes 0, 6 and 7 are unused; if the FSM ever reaches one, it goes to P1_TURN on the next edge with the board unchanged.

Legal move:
- Conditions: state is P1_TURN or P2_TURN, playerWrite=1, playerInput <= 8, and the target cell is 00.
- On the edge, the cell is written with the current player's code (01 or 10).
- The result is visible on gBoard the cycle after the edge: 1-cycle latency.

Illegal moves:
- An occupied cell, an index > 8, or playerWrite=0 changes nothing: board and turn are unchanged, and the same player keeps the turn.

Win and draw evaluation:
- Evaluated on the next-board value (board including the move), so the terminal state appears on the same edge as the winning move.
- Win lines are rows (0,1,2) (3,4,5) (6,7,8), columns (0,3,6) (1,4,7) (2,5,8), and diagonals (0,4,8) (2,4,6).
- If the mover completes a line, go to P1_WIN or P2_WIN.
- Otherwise, if all 9 cells are non-empty, go to DRAW.
- Otherwise, pass the turn to the other player.

Terminal states:
- gameIsDone=1; winner = 01 / 10 / 11 for P1_WIN / P2_WIN / DRAW.
- The state and board are held, and all writes are ignored until reset.

Simultaneous events:
- reset has priority over any write in the same cycle.
- If playerWrite is held high across multiple cycles, each cycle is a separate attempt by whichever player is on turn.

Reset mid-game:
- The board clears and the first player is re-selected from isPlayer1Start.

Test Plan:
1. Reset with isPlayer1Start=0, then release → gBoard=18'h00000, outputState=2, gameIsDone=0, winner=00.
2. From scenario 1, write cell 4 → gBoard=18'h00200, outputState=1.
   - Then write cell 4 again → gBoard unchanged, outputState stays 1.
   - Then write index 12 → no change.
3. From reset with isPlayer1Start=0, play P2:0, P1:3, P2:1, P1:4, P2:2 → the board reads 18'h0016A after the last edge.
   - outputState=4, winner=10, gameIsDone=1.
   - A further write of cell 8 leaves the board at 18'h0016A.
4. With isPlayer1Start=1, play P1:0, P2:4, P1:1, P2:2, P1:6, P2:3, P1:5, P2:7, P1:8:
   - After P1 plays cell 8, no line is complete and the board is full.
   - Required: outputState=5, winner=11, gameIsDone=1.
5. With isPlayer1Start=1, play P1:2, P2:0, P1:4, P2:1, P1:6 (anti-diagonal) → outputState=3, winner=01.
6. Assert reset in the middle of scenario 3 (after the third move) with isPlayer1Start=1 → gBoard=0, outputState=1 on the next cycle. Also apply reset and playerWrite in the same cycle → reset wins.
